// File: rtl/register_file_reader_pkg.sv
// -----------------------------------------------------------------------------
// register_file_reader_pkg
//   Shared definitions for the general-purpose register file and the stages
//   that talk to it (decode supplies source register numbers, write-back
//   supplies the destination register number and data).
//
//   Contents:
//     DATA_WIDTH / ADDR_WIDTH : default register width and register-number width
//     NUM_REGS                : number of architectural registers
//     ZERO_REG                : register number hardwired to zero
//     SP_INDEX / SP_INIT      : stack pointer register number and reset value
//     reg_num_t               : register-number type for decode / write-back
//     is_zero_reg()           : helper used by decode / write-back logic
// -----------------------------------------------------------------------------
package register_file_reader_pkg;

    localparam int DATA_WIDTH = 16;
    localparam int ADDR_WIDTH = 4;
    localparam int NUM_REGS   = 1 << ADDR_WIDTH;

    localparam int ZERO_REG   = 0;
    localparam int SP_INDEX   = 2;
    localparam logic [DATA_WIDTH-1:0] SP_INIT = 16'hFFFE;

    typedef logic [ADDR_WIDTH-1:0] reg_num_t;

    function automatic logic is_zero_reg(input reg_num_t reg_num);
        return reg_num == reg_num_t'(ZERO_REG);
    endfunction

endpackage : register_file_reader_pkg

// File: rtl/register_file_reader_reg_read_port.sv
// -----------------------------------------------------------------------------
// reg_read_port
//   One registered read port of the register file: an operand latch fed by a
//   zero / write-forward / stored-value mux. The top instantiates it twice.
//
//   Ports:
//     CLK        in   clock, capture on rising edge
//     reset      in   asynchronous active-low reset, clears the latch
//     read_en    in   capture enable; latch holds when low
//     rs_addr    in   source register number for this port
//     reg_write  in   write-port enable (for same-edge forwarding)
//     rd_addr    in   write-port register number
//     rd_data    in   write-port data
//     reg_value  in   current stored value of register rs_addr
//     rs_data    out  latched read result
// -----------------------------------------------------------------------------
module reg_read_port
    import register_file_reader_pkg::*;
#(
    parameter int DATA_WIDTH = register_file_reader_pkg::DATA_WIDTH,
    parameter int ADDR_WIDTH = register_file_reader_pkg::ADDR_WIDTH
) (
    input  logic                  CLK,
    input  logic                  reset,
    input  logic                  read_en,
    input  logic [ADDR_WIDTH-1:0] rs_addr,
    input  logic                  reg_write,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [DATA_WIDTH-1:0] rd_data,
    input  logic [DATA_WIDTH-1:0] reg_value,
    output logic [DATA_WIDTH-1:0] rs_data
);

    logic [DATA_WIDTH-1:0] data_d;
    logic [DATA_WIDTH-1:0] data_q;

    // Zero register beats forwarding: a write aimed at r0 must never leak out
    // through the forward path even though the storage ignores it.
    always_comb begin
        data_d = data_q;
        if (read_en) begin
            if (rs_addr == ADDR_WIDTH'(ZERO_REG)) begin
                data_d = '0;
            end else if (reg_write && (rd_addr == rs_addr)) begin
                data_d = rd_data;
            end else begin
                data_d = reg_value;
            end
        end
    end

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign rs_data = data_q;

endmodule : reg_read_port

// File: rtl/register_file_reader.sv
// -----------------------------------------------------------------------------
// register_file_reader
//   General-purpose register file with one write port and two registered read
//   ports (the ALU A/B operand latches). Writes and captures happen on the same
//   rising edge; a same-edge write to a register being read is forwarded into
//   the read latch. Register 0 reads as zero and ignores writes. The stack
//   pointer register comes out of reset holding SP_INIT.
//
//   Ports:
//     CLK         in   system clock, all state updates on rising edge
//     reset       in   asynchronous active-low reset
//     reg_write   in   write enable
//     rd_addr     in   destination register number
//     rd_data     in   write data
//     read_en     in   capture enable for both read latches
//     rs1_addr    in   source register 1 number
//     rs2_addr    in   source register 2 number
//     rs1_data    out  registered read result, port 1
//     rs2_data    out  registered read result, port 2
//     read_valid  out  one-cycle-delayed copy of read_en
// -----------------------------------------------------------------------------
module register_file_reader
    import register_file_reader_pkg::*;
#(
    parameter int                       DATA_WIDTH = register_file_reader_pkg::DATA_WIDTH,
    parameter int                       ADDR_WIDTH = register_file_reader_pkg::ADDR_WIDTH,
    parameter int                       SP_INDEX   = register_file_reader_pkg::SP_INDEX,
    parameter logic [DATA_WIDTH-1:0]    SP_INIT    = register_file_reader_pkg::SP_INIT
) (
    input  logic                  CLK,
    input  logic                  reset,
    input  logic                  reg_write,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [DATA_WIDTH-1:0] rd_data,
    input  logic                  read_en,
    input  logic [ADDR_WIDTH-1:0] rs1_addr,
    input  logic [ADDR_WIDTH-1:0] rs2_addr,
    output logic [DATA_WIDTH-1:0] rs1_data,
    output logic [DATA_WIDTH-1:0] rs2_data,
    output logic                  read_valid
);

    localparam int REG_COUNT = 1 << ADDR_WIDTH;

    // Stored value of every register, indexed by register number.
    logic [DATA_WIDTH-1:0] reg_value [REG_COUNT];

    // Each register is its own flop group so its reset value can differ
    // (the stack pointer) and register 0 needs no storage at all.
    for (genvar g = 0; g < REG_COUNT; g++) begin : g_regs
        if (g == ZERO_REG) begin : g_zero
            assign reg_value[g] = '0;
        end else begin : g_store
            localparam logic [DATA_WIDTH-1:0] RESET_VALUE =
                (g == SP_INDEX) ? SP_INIT : '0;

            logic [DATA_WIDTH-1:0] value_d;
            logic [DATA_WIDTH-1:0] value_q;

            always_comb begin
                value_d = value_q;
                if (reg_write && (rd_addr == ADDR_WIDTH'(g))) begin
                    value_d = rd_data;
                end
            end

            always_ff @(posedge CLK or negedge reset) begin
                if (!reset) begin
                    value_q <= RESET_VALUE;
                end else begin
                    value_q <= value_d;
                end
            end

            assign reg_value[g] = value_q;
        end
    end

    reg_read_port #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_port_a (
        .CLK       (CLK),
        .reset     (reset),
        .read_en   (read_en),
        .rs_addr   (rs1_addr),
        .reg_write (reg_write),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .reg_value (reg_value[rs1_addr]),
        .rs_data   (rs1_data)
    );

    reg_read_port #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_port_b (
        .CLK       (CLK),
        .reset     (reset),
        .read_en   (read_en),
        .rs_addr   (rs2_addr),
        .reg_write (reg_write),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .reg_value (reg_value[rs2_addr]),
        .rs_data   (rs2_data)
    );

    logic read_valid_d;
    logic read_valid_q;

    always_comb begin
        read_valid_d = read_en;
    end

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            read_valid_q <= 1'b0;
        end else begin
            read_valid_q <= read_valid_d;
        end
    end

    assign read_valid = read_valid_q;

endmodule : register_file_reader

// File: tb/tb_register_file_reader.sv
// -----------------------------------------------------------------------------
// tb_register_file_reader
//   Self-checking bench for register_file_reader: directed vector table,
//   hand-written reset sequences, a register sweep and random traffic checked
//   against an array-based model of the register file.
// -----------------------------------------------------------------------------
module tb_register_file_reader;

    logic        CLK = 1'b0;
    logic        reset;
    logic        reg_write;
    logic [3:0]  rd_addr;
    logic [15:0] rd_data;
    logic        read_en;
    logic [3:0]  rs1_addr;
    logic [3:0]  rs2_addr;
    logic [15:0] rs1_data;
    logic [15:0] rs2_data;
    logic        read_valid;

    int tests = 0;
    int fails = 0;

    // Reference model state
    logic [15:0] mem [16];
    logic [15:0] m_rs1;
    logic [15:0] m_rs2;
    logic        m_valid;

    always #5 CLK = ~CLK;

    register_file_reader dut (
        .CLK        (CLK),
        .reset      (reset),
        .reg_write  (reg_write),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .read_en    (read_en),
        .rs1_addr   (rs1_addr),
        .rs2_addr   (rs2_addr),
        .rs1_data   (rs1_data),
        .rs2_data   (rs2_data),
        .read_valid (read_valid)
    );

    typedef struct {
        logic        we;
        logic [3:0]  rd;
        logic [15:0] wd;
        logic        ren;
        logic [3:0]  a1;
        logic [3:0]  a2;
        logic [15:0] e1;
        logic [15:0] e2;
        logic        ev;
    } vec_t;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) mem[i] = 16'h0000;
        mem[2]  = 16'hFFFE;
        m_rs1   = 16'h0000;
        m_rs2   = 16'h0000;
        m_valid = 1'b0;
    endtask

    function automatic logic [15:0] model_read(input logic [3:0] a, input logic we,
                                               input logic [3:0] rd, input logic [15:0] wd);
        if (a == 4'd0) return 16'h0000;
        if (we && rd == a) return wd;
        return mem[a];
    endfunction

    // Apply one cycle of inputs, advance the model across the edge, and leave
    // the time at 1 ns after the edge so outputs can be sampled.
    task automatic drive(input logic we, input logic [3:0] rd, input logic [15:0] wd,
                         input logic ren, input logic [3:0] a1, input logic [3:0] a2);
        reg_write = we;
        rd_addr   = rd;
        rd_data   = wd;
        read_en   = ren;
        rs1_addr  = a1;
        rs2_addr  = a2;
        @(posedge CLK);
        if (ren) begin
            m_rs1 = model_read(a1, we, rd, wd);
            m_rs2 = model_read(a2, we, rd, wd);
        end
        m_valid = ren;
        if (we && rd != 4'd0) mem[rd] = wd;
        #1;
    endtask

    task automatic check_model(input string tag);
        check({tag, ".rs1"},   rs1_data, m_rs1);
        check({tag, ".rs2"},   rs2_data, m_rs2);
        check({tag, ".valid"}, {15'd0, read_valid}, {15'd0, m_valid});
    endtask

    vec_t vecs [14];

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running, expected done");
        $fatal(1, "timeout");
    end

    initial begin
        reg_write = 1'b0; rd_addr = '0; rd_data = '0;
        read_en = 1'b0;  rs1_addr = '0; rs2_addr = '0;
        reset = 1'b0;
        model_reset();
        repeat (2) @(posedge CLK);
        #3 reset = 1'b1;

        // --- Reset value check: make outputs non-zero, then reset mid-cycle.
        drive(1'b0, 4'd0, 16'h0, 1'b1, 4'd2, 4'd2);
        check_model("pre_reset");
        #3 reset = 1'b0;
        #1;
        check("async_reset.rs1", rs1_data, 16'h0000);
        check("async_reset.rs2", rs2_data, 16'h0000);
        check("async_reset.valid", {15'd0, read_valid}, 16'h0000);
        model_reset();
        #2 reset = 1'b1;
        drive(1'b0, 4'd0, 16'h0, 1'b1, 4'd2, 4'd5);
        check("after_reset.rs1", rs1_data, 16'hFFFE);
        check("after_reset.rs2", rs2_data, 16'h0000);
        check("after_reset.valid", {15'd0, read_valid}, 16'h0001);
        drive(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 4'd0);
        check("valid_one_cycle", {15'd0, read_valid}, 16'h0000);

        // --- Directed vectors: write/read, hold, r0 protection, forwarding.
        //             we    rd     wd        ren   a1     a2     e1        e2        ev
        vecs[0]  = '{1'b1, 4'd3, 16'h8888, 1'b0, 4'd0, 4'd0, 16'hFFFE, 16'h0000, 1'b0};
        vecs[1]  = '{1'b0, 4'd0, 16'h0000, 1'b1, 4'd3, 4'd2, 16'h8888, 16'hFFFE, 1'b1};
        vecs[2]  = '{1'b1, 4'd3, 16'h1234, 1'b0, 4'd3, 4'd3, 16'h8888, 16'hFFFE, 1'b0};
        vecs[3]  = '{1'b1, 4'd3, 16'h1234, 1'b0, 4'd3, 4'd3, 16'h8888, 16'hFFFE, 1'b0};
        vecs[4]  = '{1'b1, 4'd3, 16'h1234, 1'b0, 4'd3, 4'd3, 16'h8888, 16'hFFFE, 1'b0};
        vecs[5]  = '{1'b1, 4'd3, 16'h1234, 1'b0, 4'd3, 4'd3, 16'h8888, 16'hFFFE, 1'b0};
        vecs[6]  = '{1'b1, 4'd3, 16'h1234, 1'b0, 4'd3, 4'd3, 16'h8888, 16'hFFFE, 1'b0};
        vecs[7]  = '{1'b1, 4'd0, 16'hFFFF, 1'b0, 4'd0, 4'd0, 16'h8888, 16'hFFFE, 1'b0};
        vecs[8]  = '{1'b0, 4'd0, 16'h0000, 1'b1, 4'd0, 4'd0, 16'h0000, 16'h0000, 1'b1};
        vecs[9]  = '{1'b1, 4'd0, 16'hFFFF, 1'b1, 4'd0, 4'd0, 16'h0000, 16'h0000, 1'b1};
        vecs[10] = '{1'b1, 4'd7, 16'hA5A5, 1'b1, 4'd7, 4'd7, 16'hA5A5, 16'hA5A5, 1'b1};
        vecs[11] = '{1'b0, 4'd0, 16'h0000, 1'b1, 4'd7, 4'd3, 16'hA5A5, 16'h1234, 1'b1};
        vecs[12] = '{1'b1, 4'd5, 16'hBEEF, 1'b1, 4'd5, 4'd7, 16'hBEEF, 16'hA5A5, 1'b1};
        vecs[13] = '{1'b0, 4'd0, 16'h0000, 1'b0, 4'd1, 4'd1, 16'hBEEF, 16'hA5A5, 1'b0};
        for (int v = 0; v < 14; v++) begin
            drive(vecs[v].we, vecs[v].rd, vecs[v].wd, vecs[v].ren, vecs[v].a1, vecs[v].a2);
            check($sformatf("vec%0d.rs1", v), rs1_data, vecs[v].e1);
            check($sformatf("vec%0d.rs2", v), rs2_data, vecs[v].e2);
            check($sformatf("vec%0d.valid", v), {15'd0, read_valid}, {15'd0, vecs[v].ev});
        end

        // --- Reset in the middle of back-to-back reads, with traffic pending.
        drive(1'b1, 4'd4, 16'h00FF, 1'b0, 4'd0, 4'd0);
        drive(1'b0, 4'd0, 16'h0, 1'b1, 4'd4, 4'd2);
        check_model("b2b0");
        drive(1'b0, 4'd0, 16'h0, 1'b1, 4'd4, 4'd2);
        check_model("b2b1");
        reg_write = 1'b1; rd_addr = 4'd4; rd_data = 16'h5555;
        #2 reset = 1'b0;
        #1;
        check("mid_reset.rs1", rs1_data, 16'h0000);
        check("mid_reset.rs2", rs2_data, 16'h0000);
        check("mid_reset.valid", {15'd0, read_valid}, 16'h0000);
        #19;
        check("held_reset.rs1", rs1_data, 16'h0000);
        check("held_reset.valid", {15'd0, read_valid}, 16'h0000);
        model_reset();
        reset = 1'b1;
        drive(1'b0, 4'd0, 16'h0, 1'b1, 4'd4, 4'd2);
        check("post_reset.r4", rs1_data, 16'h0000);
        check("post_reset.r2", rs2_data, 16'hFFFE);
        check("post_reset.valid", {15'd0, read_valid}, 16'h0001);

        // --- Sweep: r_i = 0x1111*i, read pairs (i, 16-i), read_en gaps.
        for (int i = 1; i < 16; i++) begin
            drive(1'b1, 4'(i), 16'(16'h1111 * i), 1'b0, 4'd0, 4'd0);
        end
        for (int i = 0; i < 16; i++) begin
            logic ren;
            ren = (i % 3) != 2;
            drive(1'b0, 4'd0, 16'h0, ren, 4'(i), 4'((16 - i) & 15));
            check_model($sformatf("sweep%0d", i));
            if (ren) begin
                check($sformatf("sweep%0d.abs", i), rs1_data,
                      (i == 0) ? 16'h0000 : 16'(16'h1111 * i));
            end
        end

        // --- Random traffic against the model.
        for (int n = 0; n < 300; n++) begin
            drive(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 16'($urandom),
                  1'($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)),
                  4'($urandom_range(0, 15)));
            check_model($sformatf("rand%0d", n));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_register_file_reader
